// File: rtl/pc_gen_unit_if.sv
// Purpose: groups the controller-facing signals of the program-counter unit.
//   master modport: the controller/ALU side. It drives the commit strobe, the
//                   stall, the next-PC operation and its operands. It observes
//                   the PC, the next PC, the fetch enable, the redirect pulse,
//                   the trap state and the retired-instruction count.
//   slave modport:  the pc_gen_unit itself.
// Signals:
//   upd_i, stall_i, npc_op_i, br_taken_i, imm12_i, imm5_i, alu_out_i  (to unit)
//   pc_o, npc_o, fetch_en_o, redirect_o, epc_o, cause_o, instret_o    (from unit)
interface pc_gen_unit_if #(
  parameter int XLEN = 32
);
  logic            upd_i;
  logic            stall_i;
  logic [1:0]      npc_op_i;
  logic            br_taken_i;
  logic [11:0]     imm12_i;
  logic [4:0]      imm5_i;
  logic [XLEN-1:0] alu_out_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] npc_o;
  logic            fetch_en_o;
  logic            redirect_o;
  logic [XLEN-1:0] epc_o;
  logic [1:0]      cause_o;
  logic [XLEN-1:0] instret_o;

  modport master (
    output upd_i, stall_i, npc_op_i, br_taken_i, imm12_i, imm5_i, alu_out_i,
    input  pc_o, npc_o, fetch_en_o, redirect_o, epc_o, cause_o, instret_o
  );

  modport slave (
    input  upd_i, stall_i, npc_op_i, br_taken_i, imm12_i, imm5_i, alu_out_i,
    output pc_o, npc_o, fetch_en_o, redirect_o, epc_o, cause_o, instret_o
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Purpose: program-counter unit. It owns the PC register and computes the next
//   PC: sequential step, conditional branch, register jump or trap vector. It
//   commits the next PC on an unstalled update. It handles trap entry, including
//   misaligned targets, by capturing the EPC and the cause. It also counts
//   retired instructions.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - pc_gen_unit_if.slave:
//          inputs:  upd_i, stall_i, npc_op_i, br_taken_i, imm12_i, imm5_i,
//                   alu_out_i
//          outputs: pc_o, npc_o, fetch_en_o, redirect_o, epc_o, cause_o,
//                   instret_o
module pc_gen_unit #(
  parameter int              XLEN      = 32,
  parameter int              PC_STEP   = 1,
  parameter int              OFF_SHIFT = 0,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] TRAP_PC   = 'h100
) (
  input logic          clk,
  input logic          rst,
  pc_gen_unit_if.slave bus
);
  typedef enum logic [1:0] {BOOT, RUN, TRAP_WAIT} state_t;

  localparam logic [1:0] OP_STEP   = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_JUMP   = 2'b10;
  localparam logic [1:0] OP_TRAP   = 2'b11;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, epc_reg, instret_reg;
  logic [1:0]      cause_reg;
  logic            redirect_reg;

  logic [11:0]     imm_full;
  logic [XLEN-1:0] offset, seq_pc, br_pc, npc;
  logic            adv, nonseq, misaligned, trap_entry, fetch_en;
  logic            unused_imm_bits;

  // Bits 4:0 of imm12_i carry no offset information; imm5_i supplies them.
  assign unused_imm_bits = ^bus.imm12_i[4:0];

  assign imm_full = {bus.imm12_i[11:5], bus.imm5_i};
  assign offset   = {{(XLEN-12){imm_full[11]}}, imm_full} << OFF_SHIFT;
  assign seq_pc   = pc_reg + XLEN'(PC_STEP);
  assign br_pc    = pc_reg + offset;

  always_comb begin
    npc = seq_pc;
    unique case (bus.npc_op_i)
      OP_STEP:   npc = seq_pc;
      OP_BRANCH: npc = bus.br_taken_i ? br_pc : seq_pc;
      OP_JUMP:   npc = bus.alu_out_i;
      OP_TRAP:   npc = TRAP_PC;
      default:   npc = seq_pc;
    endcase
  end

  assign nonseq = ((bus.npc_op_i == OP_BRANCH) && bus.br_taken_i) ||
                  (bus.npc_op_i == OP_JUMP);
  // Only byte-addressed memories can see a misaligned target.
  assign misaligned = (PC_STEP == 4) && nonseq && (npc[1:0] != 2'b00);

  // A stall blocks every commit, trap ops included, until it drops.
  assign adv        = (state_reg == RUN) && bus.upd_i && !bus.stall_i;
  assign trap_entry = adv && ((bus.npc_op_i == OP_TRAP) || misaligned);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= BOOT;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    fetch_en   = 1'b0;
    unique case (state_reg)
      BOOT:      state_next = RUN;
      RUN: begin
        fetch_en = 1'b1;
        if (trap_entry) state_next = TRAP_WAIT;
      end
      TRAP_WAIT: state_next = RUN;
      default:   state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      epc_reg      <= '0;
      cause_reg    <= 2'b00;
      instret_reg  <= '0;
      redirect_reg <= 1'b0;
    end else begin
      // Without a commit the pulse ends here.
      redirect_reg <= 1'b0;
      if (trap_entry) begin
        pc_reg       <= TRAP_PC;
        epc_reg      <= pc_reg;
        cause_reg    <= misaligned ? 2'b10 : 2'b01;
        redirect_reg <= 1'b1;
      end else if (adv) begin
        pc_reg       <= npc;
        instret_reg  <= instret_reg + 1'b1;
        redirect_reg <= nonseq;
      end
    end
  end

  assign bus.pc_o       = pc_reg;
  assign bus.npc_o      = npc;
  assign bus.fetch_en_o = fetch_en;
  assign bus.redirect_o = redirect_reg;
  assign bus.epc_o      = epc_reg;
  assign bus.cause_o    = cause_reg;
  assign bus.instret_o  = instret_reg;
endmodule
